// File: rtl/bus_pkg.sv
// Shared definitions for serial-bus endpoints: field widths, device-select
// slice and the target-side state encoding.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned BUS_DATA_W = 8;
    localparam int unsigned DEVSEL_MSB = 15;
    localparam int unsigned DEVSEL_LSB = 12;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StWrite,
        StReadReq,
        StReadWait,
        StRdataTx
    } target_state_e;

    // Device-select field of a full bus address
    function automatic logic [DEVSEL_MSB-DEVSEL_LSB:0] devsel(input logic [BUS_ADDR_W-1:0] addr);
        return addr[DEVSEL_MSB:DEVSEL_LSB];
    endfunction

endpackage

// File: rtl/serial_tx_shifter.sv
// LSB-first parallel-to-serial shifter. A load pulse captures a word; the
// word then leaves one bit per cycle with o_valid high, without pausing.
module serial_tx_shifter
    import bus_pkg::*;
#(
    parameter int unsigned W = BUS_DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_bit,
    output logic         o_valid
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]    r_shift;
    logic [CntW-1:0] r_cnt;
    logic            r_active;

    // Load a word, then shift it out LSB first for exactly W cycles
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == CntW'(W - 1)) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_bit   = r_shift[0] & r_active;
    assign o_valid = r_active;

endmodule

// File: rtl/target_port.sv
// Serial-bus target endpoint: deserialises address and write data, drives a
// local memory interface, and serialises read data back to the initiator.
// Optional split signalling on long read waits is enabled by defining
// TARGET_SPLIT_EN; without it target_split is tied low.
module target_port
    import bus_pkg::*;
#(
    parameter logic [3:0]  DEVICE_ID     = 4'h0,
    parameter int unsigned LOCAL_AW      = 12,
    parameter int unsigned SPLIT_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_mode,
    input  logic                  bus_init_rw,
    input  logic                  bus_init_ready,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  target_ack,
    output logic                  target_split,
    output logic [LOCAL_AW-1:0]   mem_addr,
    output logic [BUS_DATA_W-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready,
    input  logic [BUS_DATA_W-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    target_state_e         r_state;
    logic [4:0]            r_acnt;
    logic [2:0]            r_dcnt;
    logic [BUS_ADDR_W-2:0] r_ashift;  // top bit is taken straight from the bus
    logic [BUS_DATA_W-2:0] r_dshift;
    logic [LOCAL_AW-1:0]   r_mem_addr;
    logic [BUS_DATA_W-1:0] r_wdata;
    logic [BUS_DATA_W-1:0] r_rdata;
    logic                  r_mem_we;
    logic                  r_mem_re;
    logic                  r_ack;
    logic                  r_tx_started;

    logic                  w_addr_bit;
    logic                  w_data_bit;
    logic [BUS_ADDR_W-1:0] w_addr_full;
    logic                  w_tx_load;

    assign w_addr_bit  = bus_data_in_valid & ~bus_mode;
    assign w_data_bit  = bus_data_in_valid & bus_mode;
    assign w_addr_full = {bus_data_in, r_ashift};
    // Read data leaves once the initiator is ready; ready is not looked at again
    assign w_tx_load   = (r_state == StRdataTx) & ~r_tx_started & bus_init_ready;

    // Transaction sequencing with registered memory and bus handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_acnt       <= '0;
            r_dcnt       <= '0;
            r_ashift     <= '0;
            r_dshift     <= '0;
            r_mem_addr   <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_ack        <= 1'b0;
            r_tx_started <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_addr_bit) begin
                        r_ashift[0] <= bus_data_in;
                        r_acnt      <= 5'd1;
                        r_state     <= StAddr;
                    end
                end
                StAddr: begin
                    if (w_addr_bit) begin
                        if (r_acnt == 5'd15) begin
                            r_acnt <= '0;
                            r_dcnt <= '0;
                            if (devsel(w_addr_full) != DEVICE_ID) begin
                                r_state <= StIdle;
                            end else begin
                                r_mem_addr <= w_addr_full[LOCAL_AW-1:0];
                                if (bus_init_rw) begin
                                    r_state <= StWdata;
                                end else begin
                                    r_mem_re <= 1'b1;
                                    r_state  <= StReadReq;
                                end
                            end
                        end else begin
                            r_ashift[r_acnt[3:0]] <= bus_data_in;
                            r_acnt                <= r_acnt + 5'd1;
                        end
                    end
                end
                StWdata: begin
                    if (w_addr_bit) begin
                        // Initiator abandoned the write: this bit starts a new address
                        r_ashift[0] <= bus_data_in;
                        r_acnt      <= 5'd1;
                        r_dcnt      <= '0;
                        r_state     <= StAddr;
                    end else if (w_data_bit) begin
                        if (r_dcnt == 3'd7) begin
                            r_wdata  <= {bus_data_in, r_dshift};
                            r_mem_we <= 1'b1;
                            r_dcnt   <= '0;
                            r_state  <= StWrite;
                        end else begin
                            r_dshift[r_dcnt] <= bus_data_in;
                            r_dcnt           <= r_dcnt + 3'd1;
                        end
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        r_mem_we <= 1'b0;
                        r_ack    <= 1'b1;
                        r_state  <= StIdle;
                    end
                end
                StReadReq: begin
                    r_state <= StReadWait;
                end
                StReadWait: begin
                    if (mem_rvalid) begin
                        r_rdata      <= mem_rdata;
                        r_mem_re     <= 1'b0;
                        r_dcnt       <= '0;
                        r_tx_started <= 1'b0;
                        r_state      <= StRdataTx;
                    end
                end
                StRdataTx: begin
                    if (!r_tx_started) begin
                        if (bus_init_ready) begin
                            r_tx_started <= 1'b1;
                        end
                    end else begin
                        // r_dcnt tracks the bit on the wire; ack lines up with bit 7
                        if (r_dcnt == 3'd6) begin
                            r_ack <= 1'b1;
                        end
                        if (r_dcnt == 3'd7) begin
                            r_dcnt       <= '0;
                            r_tx_started <= 1'b0;
                            r_state      <= StIdle;
                        end else begin
                            r_dcnt <= r_dcnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    serial_tx_shifter #(
        .W (BUS_DATA_W)
    ) u_tx (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_tx_load),
        .i_data  (r_rdata),
        .o_bit   (bus_data_out),
        .o_valid (bus_data_out_valid)
    );

`ifdef TARGET_SPLIT_EN
    localparam int unsigned SplitCntW = $clog2(SPLIT_LATENCY + 1);

    logic [SplitCntW-1:0] r_wait_cnt;
    logic                 r_split_done;
    logic                 r_split;

    // Count read-wait cycles and pulse target_split once when the wait hits the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt   <= '0;
            r_split_done <= 1'b0;
            r_split      <= 1'b0;
        end else begin
            r_split <= 1'b0;
            if (r_state != StReadWait) begin
                r_wait_cnt   <= '0;
                r_split_done <= 1'b0;
            end else if (!mem_rvalid && !r_split_done) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
                if (r_wait_cnt == SplitCntW'(SPLIT_LATENCY - 1)) begin
                    r_split      <= 1'b1;
                    r_split_done <= 1'b1;
                end
            end
        end
    end

    assign target_split = r_split;
`else
    assign target_split = 1'b0;
`endif

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_wdata;
    assign mem_we     = r_mem_we;
    assign mem_re     = r_mem_re;
    assign target_ack = r_ack;

endmodule

// File: doc/target_port.md
Name: target_port

Overview:
- Bus-side slave endpoint, directly downstream of the initiator port on the shared serial bus.
- Deserialises the 16-bit address (bus_mode=0) and 8-bit write data (bus_mode=1), both LSB first.
- Decodes the device select and drives a simple local memory/register interface.
- Serialises 8-bit read data back LSB first and returns target_ack (and, optionally, target_split) to the initiator.

Parameters:
- DEVICE_ID, 4'h0, value matched against address bits [15:12]; mismatching transactions are consumed silently.
- LOCAL_AW, 12, local address width; mem_addr = captured address [LOCAL_AW-1:0].
- SPLIT_LATENCY, 8, read-wait cycles before target_split fires (only with TARGET_SPLIT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bus_data_in  in  1  serial bit from initiator
- bus_data_in_valid  in  1  bit qualifier
- bus_mode  in  1  1=data phase, 0=address phase
- bus_init_rw  in  1  1=write, 0=read; sampled with the 16th address bit
- bus_init_ready  in  1  initiator can accept read data
- bus_data_out  out  1  serial read-data bit
- bus_data_out_valid  out  1  read-data bit qualifier
- target_ack  out  1  one-cycle completion pulse
- target_split  out  1  one-cycle split pulse (0 when feature off)
- mem_addr  out  LOCAL_AW  local address
- mem_wdata  out  8  local write data
- mem_we  out  1  write request, held until mem_ready
- mem_re  out  1  read request, held until mem_rvalid
- mem_ready  in  1  write accepted
- mem_rdata  in  8  read data
- mem_rvalid  in  1  read data valid

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; bit counters 0; shift registers 0.
- Bit sampling: only on clk edges with bus_data_in_valid=1; bit k lands in shift[k].
- IDLE / ADDR:
  - A valid bit with bus_mode=0 is address bit 0; go to ADDR.
  - On the 16th bit, latch addr and rw (bus_init_rw that cycle).
  - addr[15:12]!=DEVICE_ID -> IDLE; no ack, no mem access.
  - Match and rw=1 -> WDATA.
  - Match and rw=0 -> READ_REQ.
- WDATA: collect 8 bits with bus_mode=1. After bit 7, next cycle enters WRITE with mem_we=1 and mem_addr/mem_wdata stable.
- WRITE:
  - Hold mem_we until a cycle with mem_ready=1; that cycle deassert mem_we.
  - Next cycle target_ack=1 for exactly one cycle, then IDLE.
  - Write latency from last data bit to ack with mem_ready tied 1: 2 cycles.
- READ_REQ: mem_re=1; go to READ_WAIT.
- READ_WAIT: on mem_rvalid=1, latch mem_rdata, drop mem_re, go to RDATA_TX.
- RDATA_TX:
  - Wait until bus_init_ready=1, then shift 8 bits on 8 consecutive cycles, bus_data_out_valid=1 on each.
  - target_ack=1 coincident with the 8th bit; then IDLE.
  - bus_init_ready falling mid-shift does not pause the shift (sampled once at start).
- Abort rule: a valid bit with bus_mode=0 seen in WDATA restarts address capture with that bit as bit 0; no ack is issued.
- Valid bits with bus_mode=1 in IDLE/ADDR are ignored.
- Valid bus bits received in READ_REQ/READ_WAIT/RDATA_TX are ignored; the bus is owned by the target response.
- mem_we and mem_re are never high together.
- Reset mid-transaction aborts immediately:
  - any pending mem_we/mem_re drops;
  - no ack follows.
- Counters: 5-bit address counter (0..15) and 3-bit data counter; both clear on every IDLE entry.

Optional Feature:
- TARGET_SPLIT_EN defined:
  - A READ_WAIT cycle counter starts at 0.
  - When it reaches SPLIT_LATENCY without mem_rvalid, target_split pulses for one cycle, once per transaction.
  - The read then continues normally to data + ack.
- Undefined: target_split tied 0; no counter is synthesised.

Decomposition:
- Shared bus_pkg:
  - target state enum (IDLE, ADDR, WDATA, WRITE, READ_REQ, READ_WAIT, RDATA_TX);
  - BUS_ADDR_W=16, BUS_DATA_W=8;
  - DEVSEL_MSB=15, DEVSEL_LSB=12.
- One natural sub-module: serial_tx_shifter (8-bit LSB-first load/shift with valid), reusable by other bus slaves.

Test Plan:
- Write: addr 16'h0A5C (DEVICE_ID=0), rw=1, data 8'h3C, mem_ready=1 -> mem_we one cycle with mem_addr=12'hA5C, mem_wdata=8'h3C; target_ack 2 cycles after last data bit.
- Read: addr 16'h0123, rw=0, mem_rvalid 3 cycles after mem_re with 8'hB7, bus_init_ready=1 -> bits 1,1,1,0,1,1,0,1 on bus_data_out; ack with the 8th bit.
- Mismatch: addr 16'h5123 -> no mem_we/mem_re, no ack; a following matching write completes normally.
- Backpressure: mem_ready low for 5 cycles -> mem_we held 6 cycles, data stable, single ack.
- Abort/reset: address-phase bit injected after 3 write-data bits -> no ack, new address captured. rst pulsed during READ_WAIT -> all outputs 0 asynchronously.
- Split (TARGET_SPLIT_EN, SPLIT_LATENCY=8): mem_rvalid after 12 cycles -> one split pulse at wait cycle 8, then data and ack. Without the macro, target_split stays 0.
